float_result_queue: RTL and testbench
=====================================

FLOAT_RESULT_QUEUE -- requirements
Module: float_result_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, width of exception counters.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named as follows.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  multiplier result present on in_z.
REQ-007 SHALL have port in_ready  output  1  queue accepts in_z this cycle.
REQ-008 SHALL have port in_z  input  32  IEEE-754 single-precision product from the float multiplier.
REQ-009 SHALL have port in_overflow  input  1  multiplier overflow flag accompanying in_z.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes head entry.
REQ-012 SHALL have port out_z  output  32  head entry value.
REQ-013 SHALL have port out_class  output  3  head entry class: 0 normal, 1 zero, 2 subnormal, 3 inf, 4 nan.
REQ-014 SHALL have port level  output  clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port clear  input  1  synchronous clear of counters only.
REQ-016 SHALL have port nan_count  output  CNT_W  accepted NaN results.
REQ-017 SHALL have port inf_count  output  CNT_W  accepted inf results.
REQ-018 SHALL have port ovf_count  output  CNT_W  accepted results with in_overflow=1.

Function
REQ-019 SHALL accept (push) when in_valid & in_ready at a rising clk edge; SHALL pop when out_valid & out_ready.
REQ-020 SHALL drive in_ready = (level != DEPTH), no combinational dependence on out_ready.
REQ-021 SHALL be first-word-fall-through: entry pushed at edge N is visible on out_z/out_class after edge N when queue was empty (latency 1 cycle).
REQ-022 SHALL classify in_z at push: exp=0xFF & mant!=0 -> nan; exp=0xFF & mant=0 -> inf; exp=0 & mant=0 -> zero (either sign); exp=0 & mant!=0 -> subnormal; else normal.
REQ-023 SHALL store class with the entry; out_class SHALL match out_z's entry.
REQ-024 SHALL handle simultaneous push and pop: level unchanged; when full, push is refused (in_ready=0) and pop proceeds.
REQ-025 SHALL keep out_z/out_class stable while out_valid=1 and out_ready=0.
REQ-026 SHALL wrap read/write pointers modulo DEPTH.
REQ-027 SHALL increment nan_count/inf_count/ovf_count by 1 per accepted matching entry, saturating at all-ones.
REQ-028 SHALL zero counters on clear; clear coincident with an accepted increment SHALL yield 0.
REQ-029 SHALL ignore in_z/in_overflow when not pushing; counters SHALL NOT change on refused pushes.

Reset
REQ-030 SHALL, while rst_n=0, force level=0, out_valid=0, in_ready=0, all counters=0, pointers=0, out_z=0, out_class=0.
REQ-031 SHALL release in_ready=1 the first edge after rst_n rises; reset mid-operation SHALL discard all entries.

Structure
REQ-032 SHALL take class encodings, exponent/mantissa field positions and widths from the shared float definitions package.
REQ-033 SHALL instantiate one storage sub-module float_fifo (parameterised width/depth, FWFT); classification and counters live in the top.

Verification
REQ-034 Push 0x3F800000 into empty queue, out_ready=1 -> next cycle out_valid=1, out_z=0x3F800000, out_class=0, then level=0.
REQ-035 Push 0x7FC00000, 0x7F800000, 0x80000000, 0x00000001 -> out_class 4,3,1,2 in order; nan_count=1, inf_count=1.
REQ-036 out_ready=0, push 5 values -> in_ready=0 after 4th, level=4, 5th held; first popped = first pushed.
REQ-037 Full queue, in_valid=1, out_ready=1 -> one pop, no push that cycle, level=3, next cycle push accepted.
REQ-038 CNT_W=2, push 5 NaNs with in_overflow=1 -> nan_count=3, ovf_count=3; clear -> both 0.
REQ-039 Level=3, assert rst_n=0 mid-cycle -> immediate out_valid=0, level=0, counters=0.

Source files
------------

// File: rtl/float_result_queue_pkg.sv
// Shared single-precision field layout, result class encodings and the
// classifier used when results enter the queue.
package float_result_queue_pkg;

   localparam int unsigned FloatW = 32;
   localparam int unsigned ExpW   = 8;
   localparam int unsigned MantW  = 23;
   localparam int unsigned ExpLsb = MantW;
   localparam int unsigned ExpMsb = ExpLsb + ExpW - 1;
   localparam int unsigned ClsW   = 3;

   typedef enum logic [ClsW-1:0] {
      ClsNormal = 3'd0,
      ClsZero   = 3'd1,
      ClsSub    = 3'd2,
      ClsInf    = 3'd3,
      ClsNan    = 3'd4
   } fclass_e;

   function automatic fclass_e classify(input logic [FloatW-1:0] z);
      logic [ExpW-1:0]  e;
      logic [MantW-1:0] m;
      fclass_e          c;
      e = z[ExpMsb:ExpLsb];
      m = z[MantW-1:0];
      if (&e)        c = (|m) ? ClsNan : ClsInf;
      else if (~|e)  c = (|m) ? ClsSub : ClsZero;
      else           c = ClsNormal;
      return c;
   endfunction

endpackage

// File: rtl/float_fifo.sv
// First-word-fall-through FIFO; the head entry is visible whenever valid=1.
module float_fifo #(
   parameter int unsigned Width = 35,
   parameter int unsigned Depth = 4,
   localparam int unsigned PtrW = $clog2(Depth),
   localparam int unsigned LvlW = $clog2(Depth) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] wdata,
   output logic [Width-1:0] rdata,
   output logic             valid,
   output logic [LvlW-1:0]  level
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LvlW-1:0]  cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign push_ok = push && (cnt_q != LvlW'(Depth));
   assign pop_ok  = pop && (cnt_q != '0);

   always_comb begin
      cnt_d = cnt_q + LvlW'(push_ok) - LvlW'(pop_ok);
   end

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

   assign valid = (cnt_q != '0);
   assign level = cnt_q;
   assign rdata = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/float_result_queue.sv
// Queue for multiplier products: classifies each accepted result, stores the
// class alongside it, and keeps saturating NaN/inf/overflow counters.
module float_result_queue
   import float_result_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16,
   localparam int unsigned LvlW = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_z,
   input  logic              in_overflow,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_z,
   output logic [2:0]        out_class,
   output logic [LvlW-1:0]   level,
   input  logic              clear,
   output logic [CNT_W-1:0]  nan_count,
   output logic [CNT_W-1:0]  inf_count,
   output logic [CNT_W-1:0]  ovf_count
);

   localparam int unsigned EntW = ClsW + FloatW;

   logic             rdy_q;
   logic             push, pop;
   fclass_e          in_cls;
   logic [EntW-1:0]  rdata;
   logic [CNT_W-1:0] nan_q, nan_d, inf_q, inf_d, ovf_q, ovf_d;

   // Holds in_ready low through reset and until the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_q <= 1'b0;
      else        rdy_q <= 1'b1;
   end

   assign in_ready = rdy_q && (level != LvlW'(DEPTH));
   assign push     = in_valid && in_ready;
   assign pop      = out_valid && out_ready;
   assign in_cls   = classify(in_z);

   float_fifo #(
      .Width (EntW),
      .Depth (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .wdata ({in_cls, in_z}),
      .rdata (rdata),
      .valid (out_valid),
      .level (level)
   );

   assign out_z     = rdata[FloatW-1:0];
   assign out_class = rdata[EntW-1:FloatW];

   always_comb begin
      nan_d = nan_q;
      inf_d = inf_q;
      ovf_d = ovf_q;
      if (clear) begin
         nan_d = '0;
         inf_d = '0;
         ovf_d = '0;
      end else if (push) begin
         if (in_cls == ClsNan && nan_q != '1) nan_d = nan_q + 1'b1;
         if (in_cls == ClsInf && inf_q != '1) inf_d = inf_q + 1'b1;
         if (in_overflow && ovf_q != '1)      ovf_d = ovf_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nan_q <= '0;
         inf_q <= '0;
         ovf_q <= '0;
      end else begin
         nan_q <= nan_d;
         inf_q <= inf_d;
         ovf_q <= ovf_d;
      end
   end

   assign nan_count = nan_q;
   assign inf_count = inf_q;
   assign ovf_count = ovf_q;

endmodule

// File: tb/tb_float_result_queue.sv
// Scenario bench for float_result_queue with a scoreboard of expected entries.
module tb_float_result_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      in_z = '0;
   logic             in_overflow = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_z;
   logic [2:0]       out_class;
   logic [2:0]       level;
   logic             clear = 1'b0;
   logic [CNT_W-1:0] nan_count, inf_count, ovf_count;

   typedef struct packed {
      logic [2:0]  c;
      logic [31:0] z;
   } ent_t;

   ent_t       sb[$];
   logic [2:0] exp_cls = '0;
   int         n_chk = 0;
   int         n_fail = 0;

   always #5 clk = ~clk;

   float_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_z        (in_z),
      .in_overflow (in_overflow),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_z       (out_z),
      .out_class   (out_class),
      .level       (level),
      .clear       (clear),
      .nan_count   (nan_count),
      .inf_count   (inf_count),
      .ovf_count   (ovf_count)
   );

   // One clock: record an accepted push in the scoreboard, capture the head if popped.
   task automatic tick(output logic popped, output ent_t seen);
      logic pu;
      pu       = in_valid && in_ready;
      popped   = out_valid && out_ready;
      seen.c   = out_class;
      seen.z   = out_z;
      if (pu) sb.push_back({exp_cls, in_z});
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      logic p;
      ent_t s;
      in_valid = 1'b0;
      clear    = 1'b1;
      tick(p, s);
      clear    = 1'b0;
   endtask

   task automatic test_reset();
      logic p;
      ent_t s;
      #2 rst_n = 1'b0;
      #10;
      n_chk++;
      if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: level=%0d out_valid=%b in_ready=%b, want 0 0 0",
                  level, out_valid, in_ready);
      end
      n_chk++;
      if (nan_count !== '0 || inf_count !== '0 || ovf_count !== '0 ||
          out_z !== 32'h0 || out_class !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_data: cnt=%0d/%0d/%0d z=%h cls=%0d, want all 0",
                  nan_count, inf_count, ovf_count, out_z, out_class);
      end
      @(posedge clk);
      #3 rst_n = 1'b1;
      #1;
      n_chk++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_before_edge: in_ready=%b, want 0", in_ready);
      end
      tick(p, s);
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_edge: in_ready=%b, want 1", in_ready);
      end
   endtask

   task automatic test_single();
      logic p;
      ent_t s, e;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_z      = 32'h3F80_0000;
      exp_cls   = 3'd0;
      tick(p, s);
      in_valid  = 1'b0;
      n_chk++;
      if (out_valid !== 1'b1 || out_z !== 32'h3F80_0000 || out_class !== 3'd0 ||
          level !== 3'd1) begin
         n_fail++;
         $display("FAIL single_fwft: v=%b z=%h cls=%0d lvl=%0d, want 1 3f800000 0 1",
                  out_valid, out_z, out_class, level);
      end
      tick(p, s);
      n_chk++;
      if (!p || sb.size() == 0) begin
         n_fail++;
         $display("FAIL single_pop: popped=%b sb=%0d, want 1 and pending entry", p, sb.size());
      end else begin
         e = sb.pop_front();
         if (s !== e) begin
            n_fail++;
            $display("FAIL single_data: got %h/%0d want %h/%0d", s.z, s.c, e.z, e.c);
         end
      end
      n_chk++;
      if (level !== 3'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_empty: level=%0d v=%b, want 0 0", level, out_valid);
      end
   endtask

   task automatic test_classes();
      logic        p;
      ent_t        s, e;
      logic [31:0] vals [4];
      logic [2:0]  clss [4];
      vals = '{32'h7FC0_0000, 32'h7F80_0000, 32'h8000_0000, 32'h0000_0001};
      clss = '{3'd4, 3'd3, 3'd1, 3'd2};
      do_clear();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_z     = vals[i];
         exp_cls  = clss[i];
         tick(p, s);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 12 && sb.size() > 0; i++) begin
         tick(p, s);
         if (p) begin
            e = sb.pop_front();
            n_chk++;
            if (s !== e) begin
               n_fail++;
               $display("FAIL class_data: got %h/%0d want %h/%0d", s.z, s.c, e.z, e.c);
            end
         end
      end
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL class_drain: %0d entries left, want 0", sb.size());
      end
      n_chk++;
      if (nan_count !== 2'd1 || inf_count !== 2'd1 || ovf_count !== 2'd0) begin
         n_fail++;
         $display("FAIL class_counts: nan=%0d inf=%0d ovf=%0d, want 1 1 0",
                  nan_count, inf_count, ovf_count);
      end
   endtask

   task automatic test_fill();
      logic p;
      ent_t s, e;
      do_clear();
      out_ready   = 1'b0;
      in_overflow = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_z     = 32'h4000_0000 + i;
         exp_cls  = 3'd0;
         tick(p, s);
      end
      n_chk++;
      if (in_ready !== 1'b0 || level !== 3'd4 || out_z !== 32'h4000_0000) begin
         n_fail++;
         $display("FAIL fill_full: rdy=%b lvl=%0d z=%h, want 0 4 40000000",
                  in_ready, level, out_z);
      end
      in_z        = 32'h7FC0_0000;
      in_overflow = 1'b1;
      exp_cls     = 3'd4;
      tick(p, s);
      n_chk++;
      if (level !== 3'd4 || nan_count !== 2'd0 || ovf_count !== 2'd0 ||
          out_z !== 32'h4000_0000) begin
         n_fail++;
         $display("FAIL fill_refused: lvl=%0d nan=%0d ovf=%0d z=%h, want 4 0 0 40000000",
                  level, nan_count, ovf_count, out_z);
      end
      out_ready = 1'b1;
      tick(p, s);
      n_chk++;
      if (!p || sb.size() == 0) begin
         n_fail++;
         $display("FAIL full_pop: popped=%b sb=%0d, want 1", p, sb.size());
      end else begin
         e = sb.pop_front();
         if (s !== e) begin
            n_fail++;
            $display("FAIL full_pop_data: got %h/%0d want %h/%0d", s.z, s.c, e.z, e.c);
         end
      end
      n_chk++;
      if (level !== 3'd3 || nan_count !== 2'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL full_simul: lvl=%0d nan=%0d rdy=%b, want 3 0 1",
                  level, nan_count, in_ready);
      end
      out_ready = 1'b0;
      tick(p, s);
      n_chk++;
      if (level !== 3'd4 || nan_count !== 2'd1 || ovf_count !== 2'd1) begin
         n_fail++;
         $display("FAIL held_push: lvl=%0d nan=%0d ovf=%0d, want 4 1 1",
                  level, nan_count, ovf_count);
      end
      in_valid    = 1'b0;
      in_overflow = 1'b0;
      out_ready   = 1'b1;
      for (int i = 0; i < 12 && sb.size() > 0; i++) begin
         tick(p, s);
         if (p) begin
            e = sb.pop_front();
            n_chk++;
            if (s !== e) begin
               n_fail++;
               $display("FAIL fill_data: got %h/%0d want %h/%0d", s.z, s.c, e.z, e.c);
            end
         end
      end
      n_chk++;
      if (sb.size() != 0 || level !== 3'd0) begin
         n_fail++;
         $display("FAIL fill_drain: sb=%0d lvl=%0d, want 0 0", sb.size(), level);
      end
   endtask

   task automatic test_saturate();
      logic p;
      ent_t s, e;
      do_clear();
      out_ready   = 1'b1;
      in_overflow = 1'b1;
      exp_cls     = 3'd4;
      for (int i = 1; i <= 5; i++) begin
         in_valid = 1'b1;
         in_z     = 32'h7FC0_0000 + i;
         tick(p, s);
         if (p) begin
            e = sb.pop_front();
            n_chk++;
            if (s !== e) begin
               n_fail++;
               $display("FAIL sat_data: got %h/%0d want %h/%0d", s.z, s.c, e.z, e.c);
            end
         end
      end
      in_valid = 1'b0;
      n_chk++;
      if (nan_count !== 2'd3 || ovf_count !== 2'd3 || inf_count !== 2'd0) begin
         n_fail++;
         $display("FAIL sat_counts: nan=%0d ovf=%0d inf=%0d, want 3 3 0",
                  nan_count, ovf_count, inf_count);
      end
      in_valid = 1'b1;
      in_z     = 32'hFFC0_0000;
      clear    = 1'b1;
      tick(p, s);
      if (p) void'(sb.pop_front());
      clear       = 1'b0;
      in_valid    = 1'b0;
      in_overflow = 1'b0;
      n_chk++;
      if (nan_count !== 2'd0 || ovf_count !== 2'd0) begin
         n_fail++;
         $display("FAIL clear_wins: nan=%0d ovf=%0d, want 0 0", nan_count, ovf_count);
      end
      for (int i = 0; i < 12 && sb.size() > 0; i++) begin
         tick(p, s);
         if (p) begin
            e = sb.pop_front();
            n_chk++;
            if (s !== e) begin
               n_fail++;
               $display("FAIL sat_drain_data: got %h/%0d want %h/%0d", s.z, s.c, e.z, e.c);
            end
         end
      end
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sat_drain: %0d entries left, want 0", sb.size());
      end
   endtask

   task automatic test_mid_reset();
      logic p;
      ent_t s;
      out_ready = 1'b0;
      exp_cls   = 3'd3;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_z     = 32'h7F80_0000;
         tick(p, s);
      end
      in_valid = 1'b0;
      n_chk++;
      if (level !== 3'd3 || inf_count == 2'd0) begin
         n_fail++;
         $display("FAIL pre_reset: lvl=%0d inf=%0d, want 3 and nonzero", level, inf_count);
      end
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b0 ||
          nan_count !== '0 || inf_count !== '0 || ovf_count !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: v=%b lvl=%0d rdy=%b cnt=%0d/%0d/%0d, want all 0",
                  out_valid, level, in_ready, nan_count, inf_count, ovf_count);
      end
      sb.delete();
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick(p, s);
      n_chk++;
      if (in_ready !== 1'b1 || level !== 3'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset: rdy=%b lvl=%0d v=%b, want 1 0 0",
                  in_ready, level, out_valid);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_classes();
      test_fill();
      test_saturate();
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
